// File: rtl/control_unit_if.sv
// control_unit_if
//   Bundles the sequencer's view of the datapath: instruction/flag/RAM/interrupt
//   inputs and every control line it drives.
//   master : control_unit side (drives control lines, reads status)
//   slave  : datapath / RAM / interrupt side
interface control_unit_if;
    logic [31:0] instruction;
    logic [3:0]  aluCarryFlags;
    logic        ramMFC;
    logic        hardwareInterrupt;
    logic        maskableInterrupt;

    logic        trapMux;
    logic        signExtend;
    logic        clearPC;
    logic        regFileRW;
    logic [4:0]  regFileRD;
    logic [4:0]  regFileRS;
    logic [4:0]  regFileRT;
    logic [1:0]  aluSign;
    logic [3:0]  aluOperation;
    logic [1:0]  ramDataSize;
    logic        ramMFA;
    logic        ramRW;
    logic [8:0]  ramAddress;
    logic        pcEnable;
    logic        irEnable;
    logic        marEnable;
    logic        mdrEnable;
    logic [1:0]  muxSignals;
    logic        muxSignals2;
    logic [1:0]  muxSignals3;

    modport master (
        input  instruction, aluCarryFlags, ramMFC, hardwareInterrupt, maskableInterrupt,
        output trapMux, signExtend, clearPC, regFileRW, regFileRD, regFileRS, regFileRT,
               aluSign, aluOperation, ramDataSize, ramMFA, ramRW, ramAddress,
               pcEnable, irEnable, marEnable, mdrEnable, muxSignals, muxSignals2, muxSignals3
    );

    modport slave (
        output instruction, aluCarryFlags, ramMFC, hardwareInterrupt, maskableInterrupt,
        input  trapMux, signExtend, clearPC, regFileRW, regFileRD, regFileRS, regFileRT,
               aluSign, aluOperation, ramDataSize, ramMFA, ramRW, ramAddress,
               pcEnable, irEnable, marEnable, mdrEnable, muxSignals, muxSignals2, muxSignals3
    );
endinterface

// File: rtl/control_unit.sv
// control_unit
//   Multicycle microsequencer for the 32-bit datapath. Holds only the state
//   register and interrupt state (IE flag, hardware edge latch); all control
//   lines are a combinational decode of state and IR.
//   Clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : control_unit_if.master (IR, ALU flags, RAM handshake, interrupts in;
//           register/ALU/mux/load-enable/RAM controls out)
module control_unit (
    input  logic          Clk,
    input  logic          reset,
    control_unit_if.master bus
);
    localparam logic [4:0] S_RST  = 5'd0,  S_F0   = 5'd1,  S_F1   = 5'd2,  S_F2   = 5'd3,
                           S_DEC  = 5'd4,  S_RT   = 5'd5,  S_JR   = 5'd6,  S_IT   = 5'd7,
                           S_MA   = 5'd8,  S_LD   = 5'd9,  S_LWB  = 5'd10, S_SMD  = 5'd11,
                           S_ST   = 5'd12, S_BR   = 5'd13, S_BT1  = 5'd14, S_BT2  = 5'd15,
                           S_INT0 = 5'd16, S_INT1 = 5'd17, S_INT2 = 5'd18;

    logic [4:0] r_state, w_next;
    logic       r_ie, r_hw_prev, r_hw_pend, r_int_hw;

    logic [5:0] w_opcode, w_funct;
    logic [4:0] w_rs, w_rt, w_rd;
    logic       w_mfc, w_int_take, w_is_load, w_word, w_taken, w_hw_edge;
    logic       w_unused;

    assign w_opcode   = bus.instruction[31:26];
    assign w_funct    = bus.instruction[5:0];
    assign w_rs       = bus.instruction[25:21];
    assign w_rt       = bus.instruction[20:16];
    assign w_rd       = bus.instruction[15:11];
    assign w_mfc      = bus.ramMFC;
    assign w_hw_edge  = bus.hardwareInterrupt & ~r_hw_prev;
    // Hardware requests ignore IE; maskable ones need IE.
    assign w_int_take = r_hw_pend | (bus.maskableInterrupt & r_ie);
    assign w_is_load  = (w_opcode == 6'h23) || (w_opcode == 6'h20);
    assign w_word     = (w_opcode == 6'h23) || (w_opcode == 6'h2B);
    // BEQ takes on Z=1, BNE on Z=0.
    assign w_taken    = (w_opcode == 6'h04) ? bus.aluCarryFlags[0] : ~bus.aluCarryFlags[0];
    assign w_unused   = ^{bus.instruction[10:6], bus.aluCarryFlags[3:1]};

    always_comb begin
        w_next = S_RST;
        case (r_state)
            S_RST:  w_next = S_F0;
            S_F0:   w_next = w_int_take ? S_INT0 : S_F1;
            S_F1:   w_next = w_mfc ? S_F2 : S_F1;
            S_F2:   w_next = S_DEC;
            S_DEC: begin
                w_next = S_F0;
                if (w_opcode == 6'h00) begin
                    case (w_funct)
                        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                        6'h26, 6'h27, 6'h2A, 6'h2B: w_next = S_RT;
                        6'h08:                      w_next = S_JR;
                        default:                    w_next = S_F0;
                    endcase
                end else begin
                    case (w_opcode)
                        6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D: w_next = S_IT;
                        6'h23, 6'h20, 6'h2B, 6'h28:        w_next = S_MA;
                        6'h04, 6'h05:                      w_next = S_BR;
                        default:                           w_next = S_F0;
                    endcase
                end
            end
            S_RT, S_JR, S_IT: w_next = S_F0;
            S_MA:   w_next = w_is_load ? S_LD : S_SMD;
            S_LD:   w_next = w_mfc ? S_LWB : S_LD;
            S_LWB:  w_next = S_F0;
            S_SMD:  w_next = S_ST;
            S_ST:   w_next = w_mfc ? S_F0 : S_ST;
            S_BR:   w_next = w_taken ? S_BT1 : S_F0;
            S_BT1:  w_next = S_BT2;
            S_BT2:  w_next = S_F0;
            S_INT0: w_next = S_INT1;
            S_INT1: w_next = w_mfc ? S_INT2 : S_INT1;
            S_INT2: w_next = S_F0;
            default: w_next = S_RST;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_RST;
            r_ie      <= 1'b1;
            r_hw_prev <= 1'b0;
            r_hw_pend <= 1'b0;
            r_int_hw  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_hw_prev <= bus.hardwareInterrupt;
            // A fresh edge arriving while the latch is being cleared is kept.
            if (w_hw_edge)
                r_hw_pend <= 1'b1;
            else if (r_state == S_INT2)
                r_hw_pend <= 1'b0;
            if (r_state == S_F0 && w_int_take)
                r_int_hw <= r_hw_pend;
            if (r_state == S_JR && w_rs == 5'd27)
                r_ie <= 1'b1;
            else if (r_state == S_INT2)
                r_ie <= 1'b0;
        end
    end

    always_comb begin
        bus.trapMux      = 1'b0;
        bus.signExtend   = 1'b0;
        bus.clearPC      = 1'b0;
        bus.regFileRW    = 1'b0;
        bus.regFileRD    = w_rd;
        bus.regFileRS    = w_rs;
        bus.regFileRT    = w_rt;
        bus.aluSign      = 2'b00;
        bus.aluOperation = 4'd0;
        bus.ramDataSize  = 2'b00;
        bus.ramMFA       = 1'b0;
        bus.ramRW        = 1'b0;
        bus.ramAddress   = '0;
        bus.pcEnable     = 1'b0;
        bus.irEnable     = 1'b0;
        bus.marEnable    = 1'b0;
        bus.mdrEnable    = 1'b0;
        bus.muxSignals   = 2'd0;
        bus.muxSignals2  = 1'b0;
        bus.muxSignals3  = 2'd0;
        case (r_state)
            S_RST: bus.clearPC = 1'b1;
            S_F0: if (!w_int_take) begin
                bus.regFileRS  = 5'd0;
                bus.muxSignals = 2'd3;
                bus.marEnable  = 1'b1;
            end
            S_F1: begin
                bus.ramMFA      = 1'b1;
                bus.ramRW       = 1'b1;
                bus.ramDataSize = 2'b10;
                bus.irEnable    = w_mfc;
            end
            S_F2: begin
                bus.muxSignals   = 2'd3;
                bus.aluOperation = 4'd7;
                bus.pcEnable     = 1'b1;
            end
            S_RT: begin
                bus.regFileRW = 1'b1;
                case (w_funct)
                    6'h20:   begin bus.aluOperation = 4'd0; bus.aluSign = 2'b01; end
                    6'h22:   begin bus.aluOperation = 4'd1; bus.aluSign = 2'b01; end
                    6'h23:   bus.aluOperation = 4'd1;
                    6'h24:   bus.aluOperation = 4'd2;
                    6'h25:   bus.aluOperation = 4'd3;
                    6'h26:   bus.aluOperation = 4'd4;
                    6'h27:   bus.aluOperation = 4'd5;
                    6'h2A:   begin bus.aluOperation = 4'd6; bus.aluSign = 2'b01; end
                    6'h2B:   bus.aluOperation = 4'd6;
                    default: bus.aluOperation = 4'd0;
                endcase
            end
            S_JR: begin
                bus.regFileRT = 5'd0;
                bus.pcEnable  = 1'b1;
            end
            S_IT: begin
                bus.regFileRW  = 1'b1;
                bus.regFileRD  = w_rt;
                bus.muxSignals = 2'd1;
                case (w_opcode)
                    6'h08:   begin bus.signExtend = 1'b1; bus.aluSign = 2'b01; end
                    6'h09:   bus.signExtend = 1'b1;
                    6'h0A:   begin bus.signExtend = 1'b1; bus.aluSign = 2'b01; bus.aluOperation = 4'd6; end
                    6'h0C:   bus.aluOperation = 4'd2;
                    6'h0D:   bus.aluOperation = 4'd3;
                    default: bus.aluOperation = 4'd0;
                endcase
            end
            S_MA: begin
                bus.muxSignals = 2'd1;
                bus.signExtend = 1'b1;
                bus.marEnable  = 1'b1;
            end
            S_LD: begin
                bus.ramMFA      = 1'b1;
                bus.ramRW       = 1'b1;
                bus.ramDataSize = w_word ? 2'b10 : 2'b00;
                bus.muxSignals2 = 1'b1;
                bus.mdrEnable   = w_mfc;
            end
            S_LWB: begin
                bus.regFileRW  = 1'b1;
                bus.regFileRD  = w_rt;
                bus.regFileRS  = 5'd0;
                bus.muxSignals = 2'd2;
            end
            S_SMD: begin
                bus.regFileRS = 5'd0;
                bus.mdrEnable = 1'b1;
            end
            S_ST: begin
                bus.ramMFA      = 1'b1;
                bus.ramDataSize = w_word ? 2'b10 : 2'b00;
            end
            S_BR: bus.aluOperation = 4'd1;
            S_BT1: begin
                bus.regFileRW    = 1'b1;
                bus.regFileRD    = 5'd1;
                bus.regFileRS    = 5'd0;
                bus.muxSignals   = 2'd1;
                bus.signExtend   = 1'b1;
                bus.aluOperation = 4'd8;
            end
            S_BT2: begin
                bus.regFileRS  = 5'd1;
                bus.muxSignals = 2'd3;
                bus.pcEnable   = 1'b1;
            end
            S_INT0: begin
                bus.regFileRW  = 1'b1;
                bus.regFileRD  = 5'd27;
                bus.regFileRS  = 5'd0;
                bus.muxSignals = 2'd3;
            end
            S_INT1: begin
                bus.ramMFA      = 1'b1;
                bus.ramRW       = 1'b1;
                bus.ramDataSize = 2'b10;
                bus.trapMux     = 1'b1;
                bus.ramAddress  = r_int_hw ? 9'h1FC : 9'h1F8;
                bus.muxSignals2 = 1'b1;
                bus.mdrEnable   = w_mfc;
            end
            S_INT2: begin
                bus.regFileRS  = 5'd0;
                bus.muxSignals = 2'd2;
                bus.pcEnable   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
//   Directed, table-driven check of control_unit: per-instruction cycle counts
//   and execute-state control word, plus hand sequences for RAM wait states,
//   reset mid-load, taken branch and interrupt entry.
module tb_control_unit;
    logic Clk = 1'b0;
    logic reset;

    control_unit_if bus ();

    control_unit dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic [31:0] ir;
        logic [3:0]  fl;
        int unsigned cyc;
        logic        rw;
        logic [4:0]  rd, rs, rt;
        logic [3:0]  op;
        logic [1:0]  sgn, mux;
        logic        pc, sx;
        logic [1:0]  m3;
    } vec_t;

    vec_t v [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] f);
        return {6'h00, rs, rt, rd, 5'h00, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [27:0] mk(input logic rw, input logic [4:0] rd, rs, rt,
                                       input logic [3:0] op, input logic [1:0] sg, mx,
                                       input logic pc, sx, input logic [1:0] m3);
        return {rw, rd, rs, rt, op, sg, mx, pc, sx, m3};
    endfunction

    function automatic logic [27:0] exec_sig();
        return {bus.regFileRW, bus.regFileRD, bus.regFileRS, bus.regFileRT, bus.aluOperation,
                bus.aluSign, bus.muxSignals, bus.pcEnable, bus.signExtend, bus.muxSignals3};
    endfunction

    function automatic logic is_f0();
        return bus.marEnable && (bus.muxSignals == 2'd3) && (bus.regFileRS == 5'd0);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned c;
        int unsigned mfa_cnt;
        logic done;

        //            ir                              fl    cyc rw rd     rs     rt     op    sg     mux    pc    sx    m3
        v[0]  = '{rtype(5'd1, 5'd2, 5'd3, 6'h21),    4'h0, 5, 1'b1, 5'd3,  5'd1,  5'd2,  4'd0, 2'b00, 2'd0, 1'b0, 1'b0, 2'd0};
        v[1]  = '{rtype(5'd5, 5'd6, 5'd7, 6'h23),    4'h0, 5, 1'b1, 5'd7,  5'd5,  5'd6,  4'd1, 2'b00, 2'd0, 1'b0, 1'b0, 2'd0};
        v[2]  = '{rtype(5'd10, 5'd11, 5'd9, 6'h2A),  4'h0, 5, 1'b1, 5'd9,  5'd10, 5'd11, 4'd6, 2'b01, 2'd0, 1'b0, 1'b0, 2'd0};
        v[3]  = '{rtype(5'd13, 5'd14, 5'd12, 6'h2B), 4'h0, 5, 1'b1, 5'd12, 5'd13, 5'd14, 4'd6, 2'b00, 2'd0, 1'b0, 1'b0, 2'd0};
        v[4]  = '{rtype(5'd16, 5'd17, 5'd15, 6'h27), 4'h0, 5, 1'b1, 5'd15, 5'd16, 5'd17, 4'd5, 2'b00, 2'd0, 1'b0, 1'b0, 2'd0};
        v[5]  = '{rtype(5'd19, 5'd20, 5'd18, 6'h26), 4'h0, 5, 1'b1, 5'd18, 5'd19, 5'd20, 4'd4, 2'b00, 2'd0, 1'b0, 1'b0, 2'd0};
        v[6]  = '{rtype(5'd31, 5'd4, 5'd0, 6'h08),   4'h0, 5, 1'b0, 5'd0,  5'd31, 5'd0,  4'd0, 2'b00, 2'd0, 1'b1, 1'b0, 2'd0};
        v[7]  = '{itype(6'h09, 5'd2, 5'd8, 16'hFFFB), 4'h0, 5, 1'b1, 5'd8,  5'd2,  5'd8,  4'd0, 2'b00, 2'd1, 1'b0, 1'b1, 2'd0};
        v[8]  = '{itype(6'h0C, 5'd3, 5'd4, 16'h8000), 4'h0, 5, 1'b1, 5'd4,  5'd3,  5'd4,  4'd2, 2'b00, 2'd1, 1'b0, 1'b0, 2'd0};
        v[9]  = '{itype(6'h0A, 5'd7, 5'd6, 16'hFFFF), 4'h0, 5, 1'b1, 5'd6,  5'd7,  5'd6,  4'd6, 2'b01, 2'd1, 1'b0, 1'b1, 2'd0};
        v[10] = '{itype(6'h23, 5'd4, 5'd5, 16'h0008), 4'h0, 7, 1'b0, 5'd0,  5'd4,  5'd5,  4'd0, 2'b00, 2'd1, 1'b0, 1'b1, 2'd0};
        v[11] = '{itype(6'h28, 5'd2, 5'd3, 16'h0004), 4'h0, 7, 1'b0, 5'd0,  5'd2,  5'd3,  4'd0, 2'b00, 2'd1, 1'b0, 1'b1, 2'd0};
        v[12] = '{itype(6'h04, 5'd1, 5'd2, 16'hFFFE), 4'h0, 5, 1'b0, 5'd31, 5'd1,  5'd2,  4'd1, 2'b00, 2'd0, 1'b0, 1'b0, 2'd0};
        v[13] = '{itype(6'h05, 5'd1, 5'd2, 16'hFFFE), 4'h0, 7, 1'b0, 5'd31, 5'd1,  5'd2,  4'd1, 2'b00, 2'd0, 1'b0, 1'b0, 2'd0};
        v[14] = '{itype(6'h05, 5'd1, 5'd2, 16'hFFFE), 4'h1, 5, 1'b0, 5'd31, 5'd1,  5'd2,  4'd1, 2'b00, 2'd0, 1'b0, 1'b0, 2'd0};
        v[15] = '{32'hFC00_0000,                      4'h0, 4, 1'b0, 5'd0,  5'd0,  5'd0,  4'd0, 2'b00, 2'd0, 1'b0, 1'b0, 2'd0};
        v[16] = '{rtype(5'd1, 5'd2, 5'd3, 6'h3F),    4'h0, 4, 1'b0, 5'd0,  5'd0,  5'd0,  4'd0, 2'b00, 2'd0, 1'b0, 1'b0, 2'd0};
        v[17] = '{itype(6'h0D, 5'd2, 5'd1, 16'h00F0), 4'h0, 5, 1'b1, 5'd1,  5'd2,  5'd1,  4'd3, 2'b00, 2'd1, 1'b0, 1'b0, 2'd0};

        reset = 1'b0;
        bus.instruction       = 32'h0;
        bus.aluCarryFlags     = 4'h0;
        bus.ramMFC            = 1'b0;
        bus.hardwareInterrupt = 1'b0;
        bus.maskableInterrupt = 1'b0;

        // Power-on reset.
        cyc();
        chk("por clearPC", 32'(bus.clearPC), 32'd1);
        chk("por marEnable", 32'(bus.marEnable), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst release clearPC", 32'(bus.clearPC), 32'd1);
        cyc();
        chk("first F0", 32'(is_f0()), 32'd1);
        chk("first F0 clearPC", 32'(bus.clearPC), 32'd0);

        // Table-driven instructions with zero-wait RAM.
        foreach (v[i]) begin
            bus.instruction   = v[i].ir;
            bus.aluCarryFlags = v[i].fl;
            bus.ramMFC        = 1'b1;
            #1;
            c = 0;
            done = 1'b0;
            while (c < 12 && !done) begin
                cyc();
                c++;
                if (c == 4 && v[i].cyc > 4)
                    chk($sformatf("vec%0d exec", i), 32'(exec_sig()),
                        32'(mk(v[i].rw, v[i].rd, v[i].rs, v[i].rt, v[i].op, v[i].sgn,
                               v[i].mux, v[i].pc, v[i].sx, v[i].m3)));
                if (is_f0())
                    done = 1'b1;
            end
            chk($sformatf("vec%0d cycles", i), c, v[i].cyc);
        end

        // LW r5,8(r4) with MFC delayed three cycles in LD.
        bus.instruction   = itype(6'h23, 5'd4, 5'd5, 16'h0008);
        bus.aluCarryFlags = 4'h0;
        bus.ramMFC        = 1'b1;
        repeat (4) cyc();
        bus.ramMFC = 1'b0;
        cyc();
        mfa_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            bus.ramMFC = (k == 3);
            #1;
            if (bus.ramMFA) mfa_cnt++;
            chk($sformatf("lw wait%0d mdrEnable", k), 32'(bus.mdrEnable), 32'(k == 3));
            chk($sformatf("lw wait%0d ramRW", k), 32'(bus.ramRW), 32'd1);
            if (k < 3) cyc();
        end
        chk("lw ramMFA held cycles", mfa_cnt, 32'd4);
        chk("lw size", 32'(bus.ramDataSize), 32'd2);
        chk("lw mux2", 32'(bus.muxSignals2), 32'd1);
        cyc();
        chk("lwb ramMFA", 32'(bus.ramMFA), 32'd0);
        chk("lwb exec", 32'(exec_sig()),
            32'(mk(1'b1, 5'd5, 5'd0, 5'd5, 4'd0, 2'b00, 2'd2, 1'b0, 1'b0, 2'd0)));
        cyc();
        chk("lw back to F0", 32'(is_f0()), 32'd1);

        // Reset asserted while a load waits for MFC.
        bus.ramMFC = 1'b1;
        repeat (4) cyc();
        bus.ramMFC = 1'b0;
        cyc();
        chk("ld before reset ramMFA", 32'(bus.ramMFA), 32'd1);
        reset = 1'b0;
        #1;
        chk("async reset ramMFA", 32'(bus.ramMFA), 32'd0);
        chk("async reset mdrEnable", 32'(bus.mdrEnable), 32'd0);
        chk("async reset clearPC", 32'(bus.clearPC), 32'd1);
        cyc();
        reset = 1'b1;
        #1;
        chk("reset release clearPC", 32'(bus.clearPC), 32'd1);
        cyc();
        chk("post reset F0", 32'(is_f0()), 32'd1);
        chk("post reset clearPC", 32'(bus.clearPC), 32'd0);

        // BEQ taken, imm = -2.
        bus.instruction   = itype(6'h04, 5'd1, 5'd2, 16'hFFFE);
        bus.aluCarryFlags = 4'h1;
        bus.ramMFC        = 1'b1;
        repeat (5) cyc();
        chk("bt1", 32'(exec_sig()),
            32'(mk(1'b1, 5'd1, 5'd0, 5'd2, 4'd8, 2'b00, 2'd1, 1'b0, 1'b1, 2'd0)));
        cyc();
        chk("bt2", 32'(exec_sig()),
            32'(mk(1'b0, 5'd31, 5'd1, 5'd2, 4'd0, 2'b00, 2'd3, 1'b1, 1'b0, 2'd0)));
        cyc();
        chk("beq taken back to F0", 32'(is_f0()), 32'd1);

        // Maskable interrupt with IE=1.
        bus.instruction       = 32'h0;
        bus.aluCarryFlags     = 4'h0;
        bus.maskableInterrupt = 1'b1;
        #1;
        chk("mi F0 marEnable", 32'(bus.marEnable), 32'd0);
        cyc();
        chk("mi int0", 32'(exec_sig()),
            32'(mk(1'b1, 5'd27, 5'd0, 5'd0, 4'd0, 2'b00, 2'd3, 1'b0, 1'b0, 2'd0)));
        cyc();
        chk("mi int1 trapMux", 32'(bus.trapMux), 32'd1);
        chk("mi int1 ramAddress", 32'(bus.ramAddress), 32'h1F8);
        chk("mi int1 ramMFA", 32'(bus.ramMFA), 32'd1);
        chk("mi int1 mdrEnable", 32'(bus.mdrEnable), 32'd1);
        cyc();
        chk("mi int2", 32'(exec_sig()),
            32'(mk(1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 2'b00, 2'd2, 1'b1, 1'b0, 2'd0)));
        cyc();
        chk("mi masked after entry", 32'(is_f0()), 32'd1);

        // JR r27 re-enables IE; the still-pending request is then taken.
        bus.instruction = rtype(5'd27, 5'd0, 5'd0, 6'h08);
        repeat (4) cyc();
        chk("jr27 pcEnable", 32'(bus.pcEnable), 32'd1);
        cyc();
        chk("mi after jr27 marEnable", 32'(bus.marEnable), 32'd0);
        cyc();
        chk("mi after jr27 int0 RD", 32'(bus.regFileRD), 32'd27);
        repeat (2) cyc();
        bus.maskableInterrupt = 1'b0;
        cyc();
        chk("mi second entry done", 32'(is_f0()), 32'd1);

        // Hardware and maskable together: hardware vector wins.
        repeat (4) cyc();
        bus.hardwareInterrupt = 1'b1;
        bus.maskableInterrupt = 1'b1;
        cyc();
        chk("hw+mi F0 marEnable", 32'(bus.marEnable), 32'd0);
        repeat (2) cyc();
        chk("hw+mi int1 ramAddress", 32'(bus.ramAddress), 32'h1FC);
        repeat (2) cyc();
        chk("hw latch cleared, IE=0", 32'(is_f0()), 32'd1);

        // Hardware edge mid-instruction is latched and taken at F0 even with IE=0.
        bus.instruction       = 32'h0;
        bus.maskableInterrupt = 1'b0;
        bus.hardwareInterrupt = 1'b0;
        cyc();
        bus.hardwareInterrupt = 1'b1;
        cyc();
        bus.hardwareInterrupt = 1'b0;
        cyc();
        cyc();
        chk("hw pulse F0 marEnable", 32'(bus.marEnable), 32'd0);
        repeat (2) cyc();
        chk("hw pulse int1 ramAddress", 32'(bus.ramAddress), 32'h1FC);
        repeat (2) cyc();
        chk("hw pulse return F0", 32'(is_f0()), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
